data_mem_responder: RTL and testbench

- Responder end of the MEM-stage data-memory interface: it accepts load/store requests from the pipeline's memory-access side and serves them from an internal word-organised RAM.
- Request/acknowledge handshake with a parameterised access latency, RISC-V byte/half/word sizing with sign/zero extension, and misalignment detection.
- One memory-mapped LED register drives the board `leds` output.
- Sits between stage 4 and the memory controller path as the data-side target.

---
 rtl/data_mem_responder.sv | 162 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-side memory target for the MEM stage. Accepts one load/store at a
//   time over a req/ack handshake. The response comes LATENCY+1 cycles after
//   the accepting cycle. The data comes from a word-organised RAM, or from a
//   memory-mapped 4-bit LED register.
//
// Ports
//   i_clk, i_rst    clock, synchronous active-low reset
//   i_req           request valid, held with stable fields until ack
//   i_op            0 load, 1 store
//   i_addr          byte address
//   i_wdata         store data, right-justified
//   i_func_3        RISC-V size/extension code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   busy            request in flight (WAIT or RESP)
//   ack             one-cycle response pulse
//   rdata, err      load result / access error, held between responses
//   leds            LED register
module data_mem_responder #(
  parameter int          ADDR_W   = 10,
  parameter int          LATENCY  = 2,
  parameter logic [31:0] LED_ADDR = 32'hFFFF_FFF0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_func_3,
  output logic        busy,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic [3:0]  leds
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic        op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  func_3;
  } req_t;

  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t            state, state_n;
  logic [3:0]        cnt;
  req_t              req_in, req_q, cur;
  logic [3:0][7:0]   mem [2**ADDR_W];

  logic [ADDR_W-1:0] idx;
  logic              is_led, legal, commit, ram_we, led_we;
  logic [3:0]        be;
  logic [3:0][7:0]   wlane;
  logic [31:0]       word, sh, ld_val;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= S_IDLE;
    else        state <= state_n;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (i_req) state_n = (LATENCY > 0) ? S_WAIT : S_RESP;
      S_WAIT:  if (cnt == 4'd0) state_n = S_RESP;
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state != S_IDLE);
    ack  = (state == S_RESP);
  end

  // ---------------- access decode ----------------
  // With zero latency the commit edge is the accepting edge. The request is
  // then still only on the inputs, so decode from them while IDLE.
  always_comb begin
    req_in = '{op: i_op, addr: i_addr, wdata: i_wdata, func_3: i_func_3};
    cur    = (state == S_IDLE) ? req_in : req_q;
  end

  // The commit happens on any edge that enters RESP. A reset on that edge
  // suppresses the write.
  assign commit = i_rst && (state != S_RESP) && (state_n == S_RESP);

  always_comb begin
    idx    = cur.addr[ADDR_W+1:2];
    is_led = (cur.addr[31:2] == LED_ADDR[31:2]);
    word   = is_led ? {28'b0, leds} : mem[idx];

    legal = 1'b0;
    case (cur.func_3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~cur.addr[0];
      3'b010:  legal = (cur.addr[1:0] == 2'b00);
      3'b100:  legal = ~cur.op;
      3'b101:  legal = ~cur.op & ~cur.addr[0];
      default: legal = 1'b0;
    endcase

    // Store data is replicated across lanes so that only the enables select.
    case (cur.func_3[1:0])
      2'b00:   begin be = 4'b0001 << cur.addr[1:0];
                     wlane = {4{cur.wdata[7:0]}}; end
      2'b01:   begin be = cur.addr[1] ? 4'b1100 : 4'b0011;
                     wlane = {2{cur.wdata[15:0]}}; end
      default: begin be = 4'b1111; wlane = cur.wdata; end
    endcase

    sh = word >> {cur.addr[1:0], 3'b000};
    case (cur.func_3)
      3'b000:  ld_val = {{24{sh[7]}}, sh[7:0]};
      3'b001:  ld_val = {{16{sh[15]}}, sh[15:0]};
      3'b100:  ld_val = {24'b0, sh[7:0]};
      3'b101:  ld_val = {16'b0, sh[15:0]};
      default: ld_val = word;
    endcase

    ram_we = commit & legal & cur.op & ~is_led;
    led_we = commit & legal & cur.op &  is_led;
  end

  // ---------------- RAM (not reset) ----------------
  always_ff @(posedge i_clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][b] <= wlane[b];
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      req_q <= '0;
      cnt   <= 4'd0;
      rdata <= 32'd0;
      err   <= 1'b0;
      leds  <= 4'd0;
    end else begin
      if (state == S_IDLE && i_req) begin
        req_q <= req_in;
        cnt   <= CNT_INIT;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        rdata <= (legal && !cur.op) ? ld_val : 32'd0;
        err   <= ~legal;
      end
      if (led_we) leds <= cur.wdata[3:0];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int          ADDR_W    = 10;
  localparam int          RAM_BYTES = 4 * (1 << ADDR_W);
  localparam logic [31:0] LED       = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst, req, op;
  logic [31:0] addr, wdata;
  logic [2:0]  f3;
  logic        busy, ack, err, busy0, ack0, err0;
  logic [31:0] rdata, rdata0;
  logic [3:0]  leds, leds0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(2), .LED_ADDR(LED)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_op(op), .i_addr(addr),
    .i_wdata(wdata), .i_func_3(f3), .busy(busy), .ack(ack), .rdata(rdata),
    .err(err), .leds(leds));

  // Zero-latency instance sharing the same stimulus. Every request is held
  // with the same fields, so repeated acceptance leaves it with the same data.
  data_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(0), .LED_ADDR(LED)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_op(op), .i_addr(addr),
    .i_wdata(wdata), .i_func_3(f3), .busy(busy0), .ack(ack0), .rdata(rdata0),
    .err(err0), .leds(leds0));

  // ---------------- reference model ----------------
  logic [7:0] mref [RAM_BYTES];
  logic [3:0] mleds;

  task automatic model(input bit o, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] fn, output logic [31:0] rd, output bit e);
    int          n;
    bit          ok, led;
    logic [63:0] v;
    logic [31:0] lw;
    n   = 1 << fn[1:0];
    led = ((a >> 2) == (LED >> 2));
    ok  = (fn == 3'd0 || fn == 3'd1 || fn == 3'd2 || fn == 3'd4 || fn == 3'd5)
          && !(o && fn >= 3'd4) && ((a % n) == 0);
    rd = 32'd0;
    e  = !ok;
    if (ok && o) begin
      if (led) mleds = wd[3:0];
      else for (int k = 0; k < n; k++)
        mref[(a + 32'(k)) % RAM_BYTES] = 8'((wd >> (8 * k)) & 32'hFF);
    end else if (ok) begin
      v  = 64'd0;
      lw = {28'd0, mleds};
      for (int k = 0; k < n; k++) begin
        if (led) v = v | (64'((lw >> (8 * ((a + 32'(k)) % 4))) & 32'hFF) << (8 * k));
        else     v = v | (64'(mref[(a + 32'(k)) % RAM_BYTES]) << (8 * k));
      end
      if (fn < 3'd4 && n < 4 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
      rd = v[31:0];
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One handshake on the LATENCY=2 instance. lat counts the cycles from the
  // accepting cycle to the ack cycle.
  task automatic txn(input bit o, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] fn, output logic [31:0] rd, output bit e,
                     output logic [3:0] ld, output int lat);
    @(negedge clk);
    op = o; addr = a; wdata = wd; f3 = fn; req = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack && lat < 20);
    rd = rdata; e = err; ld = leds;
    @(negedge clk);
    req = 1'b0;
  endtask

  typedef struct {
    bit          o;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  fn;
    logic [31:0] er;
    bit          ee;
    logic [3:0]  el;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, mrd, hs_exp;
    bit          e, me, seen;
    logic [3:0]  ld;
    int          lat;

    tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0,        1'b0, 4'h0};
    tbl[1]  = '{1'b0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 1'b0, 4'h0};
    tbl[2]  = '{1'b0, 32'h13,  32'h0,        3'b000, 32'hFFFFFFDE, 1'b0, 4'h0};
    tbl[3]  = '{1'b0, 32'h13,  32'h0,        3'b100, 32'h000000DE, 1'b0, 4'h0};
    tbl[4]  = '{1'b0, 32'h12,  32'h0,        3'b001, 32'hFFFFDEAD, 1'b0, 4'h0};
    tbl[5]  = '{1'b0, 32'h10,  32'h0,        3'b101, 32'h0000BEEF, 1'b0, 4'h0};
    tbl[6]  = '{1'b1, 32'h11,  32'h55,       3'b000, 32'h0,        1'b0, 4'h0};
    tbl[7]  = '{1'b0, 32'h10,  32'h0,        3'b010, 32'hDEAD55EF, 1'b0, 4'h0};
    tbl[8]  = '{1'b1, 32'h12,  32'h1234,     3'b001, 32'h0,        1'b0, 4'h0};
    tbl[9]  = '{1'b0, 32'h10,  32'h0,        3'b010, 32'h123455EF, 1'b0, 4'h0};
    tbl[10] = '{1'b0, 32'h12,  32'h0,        3'b010, 32'h0,        1'b1, 4'h0};
    tbl[11] = '{1'b1, 32'h11,  32'hFFFF,     3'b001, 32'h0,        1'b1, 4'h0};
    tbl[12] = '{1'b0, 32'h10,  32'h0,        3'b010, 32'h123455EF, 1'b0, 4'h0};
    tbl[13] = '{1'b0, 32'h10,  32'h0,        3'b011, 32'h0,        1'b1, 4'h0};
    tbl[14] = '{1'b1, LED,     32'hA,        3'b010, 32'h0,        1'b0, 4'hA};
    tbl[15] = '{1'b0, LED,     32'h0,        3'b010, 32'h0000000A, 1'b0, 4'hA};

    rst = 1'b0; req = 1'b0; op = 1'b0; addr = '0; wdata = '0; f3 = '0;
    mleds = 4'd0;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_ack0", 32'(ack0), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // directed table
    foreach (tbl[i]) begin
      txn(tbl[i].o, tbl[i].a, tbl[i].wd, tbl[i].fn, rd, e, ld, lat);
      model(tbl[i].o, tbl[i].a, tbl[i].wd, tbl[i].fn, mrd, me);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd3);
      chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].ee));
      if (!tbl[i].o) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].er);
      chk($sformatf("tbl%0d_leds", i), 32'(ld), 32'(tbl[i].el));
    end

    // abort: reset sampled on the edge that would commit the store
    txn(1'b1, 32'h20, 32'h77, 3'b010, rd, e, ld, lat);
    model(1'b1, 32'h20, 32'h77, 3'b010, mrd, me);
    @(negedge clk);
    op = 1'b1; addr = 32'h20; wdata = 32'h1; f3 = 3'b010; req = 1'b1;
    @(posedge clk); #1;              // accepting edge
    seen = ack;
    @(posedge clk); #1;              // counter reaches zero
    seen = seen | ack;
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    @(posedge clk); #1;
    seen = seen | ack;
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mleds = 4'd0;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | ack;
    end
    chk("abort_no_ack", 32'(seen), 32'd0);
    txn(1'b0, 32'h20, 32'h0, 3'b010, rd, e, ld, lat);
    chk("abort_keep", rd, 32'h77);
    chk("abort_leds", 32'(ld), 32'd0);

    // randomized against the model: seed words 0..15 first
    for (int w = 0; w < 16; w++) begin
      wdata = $urandom();
      txn(1'b1, 32'(w * 4), wdata, 3'b010, rd, e, ld, lat);
      model(1'b1, 32'(w * 4), wdata, 3'b010, mrd, me);
    end
    for (int i = 0; i < 80; i++) begin
      logic [31:0] ra, rw;
      logic [2:0]  rf;
      bit          ro;
      ro = 1'($urandom_range(0, 1));
      rf = 3'($urandom_range(0, 7));
      rw = $urandom();
      if ($urandom_range(0, 7) == 0) ra = LED | 32'($urandom_range(0, 3));
      else ra = ($urandom() & 32'h7FFF_F000) | 32'($urandom_range(0, 15) * 4)
                | 32'($urandom_range(0, 3));
      model(ro, ra, rw, rf, mrd, me);
      txn(ro, ra, rw, rf, rd, e, ld, lat);
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd3);
      chk($sformatf("rnd%0d_err a=%h f=%0d o=%0d", i, ra, rf, ro), 32'(e), 32'(me));
      if (!ro) chk($sformatf("rnd%0d_rdata a=%h f=%0d", i, ra, rf), rd, mrd);
      chk($sformatf("rnd%0d_leds", i), 32'(ld), 32'(mleds));
    end

    // held request: throughput LATENCY+2, and zero-latency ack after 1 cycle
    model(1'b0, 32'h10, 32'h0, 3'b010, hs_exp, me);
    repeat (3) @(negedge clk);
    op = 1'b0; addr = 32'h10; wdata = 32'h0; f3 = 3'b010; req = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hs_ack c%0d", c), 32'(ack), 32'((c % 4) == 3));
      chk($sformatf("hs_ack0 c%0d", c), 32'(ack0), 32'((c % 2) == 1));
      if ((c % 2) == 1) chk($sformatf("hs_rdata0 c%0d", c), rdata0, hs_exp);
    end
    @(negedge clk);
    req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
